// File: rtl/bp_fe_pred_update_sched_pkg.sv
// Shared types for the front-end predictor update scheduler.
`ifndef BP_FE_PRED_UPDATE_SCHED_PKG_SV
`define BP_FE_PRED_UPDATE_SCHED_PKG_SV

// One table update: holding register, FIFO entry and write-port payload.
`define BP_FE_DECLARE_PRED_UPDATE_S(idx_mp, tag_mp, tgt_mp) \
  typedef struct packed {                                   \
    logic                clr;                               \
    logic                jmp;                               \
    logic [idx_mp-1:0]   idx;                               \
    logic [tag_mp-1:0]   tag;                               \
    logic [tgt_mp-1:0]   tgt;                               \
  } bp_fe_pred_update_s

package bp_fe_pred_update_sched_pkg;

  typedef enum logic [1:0] {
    e_reset,
    e_init,
    e_run
  } bp_fe_pred_update_sched_state_e;

  // Pointer width for a FIFO of the given depth; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_pred_update_sched_fifo.sv
// Circular attaboy FIFO with per-entry valid bits and a parallel idx kill.
module bp_fe_pred_update_sched_fifo
  import bp_fe_pred_update_sched_pkg::*;
#(
  parameter int unsigned idx_width_p   = 6,
  parameter int unsigned tag_width_p   = 9,
  parameter int unsigned tgt_width_p   = 39,
  parameter int unsigned fifo_els_p    = 4,
  parameter int unsigned entry_width_p = 2 + idx_width_p + tag_width_p + tgt_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     enq_v_i,
  input  logic [entry_width_p-1:0] enq_data_i,
  input  logic                     deq_i,
  input  logic                     kill_v_i,
  input  logic [idx_width_p-1:0]   kill_idx_i,
  output logic [entry_width_p-1:0] head_o,
  output logic                     head_v_o,
  output logic                     head_dead_o,
  output logic                     full_o
);

  localparam int unsigned ptr_width_lp = ptr_width(fifo_els_p);
  localparam int unsigned cnt_width_lp = ptr_width_lp + 1;

  `BP_FE_DECLARE_PRED_UPDATE_S(idx_width_p, tag_width_p, tgt_width_p);

  bp_fe_pred_update_s      mem_q [fifo_els_p];
  bp_fe_pred_update_s      enq_s;
  logic [fifo_els_p-1:0]   v_q, v_n;
  logic [ptr_width_lp-1:0] head_q, tail_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic                    empty, enq, deq;

  assign enq_s       = enq_data_i;
  assign empty       = (cnt_q == '0);
  assign full_o      = (cnt_q == cnt_width_lp'(fifo_els_p));
  assign enq         = enq_v_i & ~full_o;
  assign deq         = deq_i & ~empty;
  assign head_o      = mem_q[head_q];
  assign head_v_o    = ~empty & v_q[head_q];
  assign head_dead_o = ~empty & ~v_q[head_q];

  // Valid bits: kill matches first, then pop, then the new entry (never killed).
  always_comb begin
    v_n = v_q;
    for (int i = 0; i < int'(fifo_els_p); i++) begin
      if (kill_v_i && v_q[i] && (mem_q[i].idx == kill_idx_i)) v_n[i] = 1'b0;
    end
    if (deq) v_n[head_q] = 1'b0;
    if (enq) v_n[tail_q] = 1'b1;
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      v_q <= v_n;
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      if (enq && !deq)      cnt_q <= cnt_q + 1'b1;
      else if (!enq && deq) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Payload storage; contents are qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= enq_s;
  end

endmodule

// File: rtl/bp_fe_pred_update_sched.sv
// Write-port scheduler for the FE predictor tables: clear sweep, then
// redirect-priority arbitration over a buffered attaboy stream.
module bp_fe_pred_update_sched
  import bp_fe_pred_update_sched_pkg::*;
#(
  parameter int unsigned idx_width_p = 6,
  parameter int unsigned tag_width_p = 9,
  parameter int unsigned tgt_width_p = 39,
  parameter int unsigned fifo_els_p  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  output logic                   init_done_o,
  input  logic                   redir_v_i,
  output logic                   redir_ready_and_o,
  input  logic                   redir_clr_i,
  input  logic                   redir_jmp_i,
  input  logic [idx_width_p-1:0] redir_idx_i,
  input  logic [tag_width_p-1:0] redir_tag_i,
  input  logic [tgt_width_p-1:0] redir_tgt_i,
  input  logic                   attaboy_v_i,
  output logic                   attaboy_ready_and_o,
  input  logic                   attaboy_jmp_i,
  input  logic [idx_width_p-1:0] attaboy_idx_i,
  input  logic [tag_width_p-1:0] attaboy_tag_i,
  input  logic [tgt_width_p-1:0] attaboy_tgt_i,
  output logic                   w_v_o,
  output logic                   w_clr_o,
  output logic                   w_jmp_o,
  output logic [idx_width_p-1:0] w_idx_o,
  output logic [tag_width_p-1:0] w_tag_o,
  output logic [tgt_width_p-1:0] w_tgt_o,
  input  logic                   w_yumi_i
);

  `BP_FE_DECLARE_PRED_UPDATE_S(idx_width_p, tag_width_p, tgt_width_p);

  localparam int unsigned entry_width_lp = $bits(bp_fe_pred_update_s);

  bp_fe_pred_update_sched_state_e state_q, state_n;
  logic [idx_width_p-1:0]         cnt_q, cnt_n;
  logic                           held_q;
  bp_fe_pred_update_s             held_data_q;
  bp_fe_pred_update_s             redir_s, attaboy_s, head_s, w_s;
  logic                           w_v_c, redir_ready_c, attaboy_ready_c;
  logic                           held_yumi, fifo_deq;
  logic                           redir_accept, attaboy_accept;
  logic                           head_v, head_dead, fifo_full;

  assign redir_s = '{clr: redir_clr_i, jmp: redir_jmp_i, idx: redir_idx_i,
                     tag: redir_tag_i, tgt: redir_tgt_i};
  assign attaboy_s = '{clr: 1'b0, jmp: attaboy_jmp_i, idx: attaboy_idx_i,
                       tag: attaboy_tag_i, tgt: attaboy_tgt_i};

  assign redir_accept   = redir_v_i & redir_ready_c;
  assign attaboy_accept = attaboy_v_i & attaboy_ready_c;

  // State and sweep counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_reset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next state, sweep advance, write-port select and handshakes.
  always_comb begin
    state_n         = state_q;
    cnt_n           = cnt_q;
    w_v_c           = 1'b0;
    w_s             = '0;
    redir_ready_c   = 1'b0;
    attaboy_ready_c = 1'b0;
    held_yumi       = 1'b0;
    fifo_deq        = 1'b0;
    case (state_q)
      e_reset: begin
        state_n = e_init;
      end
      e_init: begin
        w_v_c   = 1'b1;
        w_s.clr = 1'b1;
        w_s.idx = cnt_q;
        if (w_yumi_i) begin
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == '1) state_n = e_run;
        end
      end
      e_run: begin
        attaboy_ready_c = ~fifo_full;
        if (held_q) begin
          w_v_c     = 1'b1;
          w_s       = held_data_q;
          held_yumi = w_yumi_i;
        end else if (head_v) begin
          w_v_c    = 1'b1;
          w_s      = head_s;
          w_s.clr  = 1'b0;
          fifo_deq = w_yumi_i;
        end
        // Killed heads drain one per cycle without using the write port.
        if (head_dead) fifo_deq = 1'b1;
        redir_ready_c = ~held_q | held_yumi;
      end
      default: begin
        state_n = e_reset;
      end
    endcase
  end

  // One-entry redirect holding register; refills in the cycle it drains.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      held_q      <= 1'b0;
      held_data_q <= '0;
    end else if (redir_accept) begin
      held_q      <= 1'b1;
      held_data_q <= redir_s;
    end else if (held_yumi) begin
      held_q      <= 1'b0;
    end
  end

  bp_fe_pred_update_sched_fifo #(
    .idx_width_p  (idx_width_p),
    .tag_width_p  (tag_width_p),
    .tgt_width_p  (tgt_width_p),
    .fifo_els_p   (fifo_els_p),
    .entry_width_p(entry_width_lp)
  ) attaboy_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enq_v_i    (attaboy_accept),
    .enq_data_i (attaboy_s),
    .deq_i      (fifo_deq),
    .kill_v_i   (redir_accept),
    .kill_idx_i (redir_idx_i),
    .head_o     (head_s),
    .head_v_o   (head_v),
    .head_dead_o(head_dead),
    .full_o     (fifo_full)
  );

  assign init_done_o         = (state_q == e_run);
  assign redir_ready_and_o   = redir_ready_c;
  assign attaboy_ready_and_o = attaboy_ready_c;
  assign w_v_o               = w_v_c;
  assign w_clr_o             = w_s.clr;
  assign w_jmp_o             = w_s.jmp;
  assign w_idx_o             = w_s.idx;
  assign w_tag_o             = w_s.tag;
  assign w_tgt_o             = w_s.tgt;

endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
// Scoreboard bench for bp_fe_pred_update_sched.
module tb_bp_fe_pred_update_sched;

  localparam int unsigned IW = 6;
  localparam int unsigned TW = 9;
  localparam int unsigned GW = 39;
  localparam int unsigned W  = 2 + IW + TW + GW;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          init_done_o;
  logic          redir_v_i, redir_ready_and_o, redir_clr_i, redir_jmp_i;
  logic [IW-1:0] redir_idx_i;
  logic [TW-1:0] redir_tag_i;
  logic [GW-1:0] redir_tgt_i;
  logic          attaboy_v_i, attaboy_ready_and_o, attaboy_jmp_i;
  logic [IW-1:0] attaboy_idx_i;
  logic [TW-1:0] attaboy_tag_i;
  logic [GW-1:0] attaboy_tgt_i;
  logic          w_v_o, w_clr_o, w_jmp_o;
  logic [IW-1:0] w_idx_o;
  logic [TW-1:0] w_tag_o;
  logic [GW-1:0] w_tgt_o;
  logic          w_yumi_i;

  logic [W-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  bp_fe_pred_update_sched dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .init_done_o(init_done_o),
    .redir_v_i(redir_v_i), .redir_ready_and_o(redir_ready_and_o),
    .redir_clr_i(redir_clr_i), .redir_jmp_i(redir_jmp_i), .redir_idx_i(redir_idx_i),
    .redir_tag_i(redir_tag_i), .redir_tgt_i(redir_tgt_i),
    .attaboy_v_i(attaboy_v_i), .attaboy_ready_and_o(attaboy_ready_and_o),
    .attaboy_jmp_i(attaboy_jmp_i), .attaboy_idx_i(attaboy_idx_i),
    .attaboy_tag_i(attaboy_tag_i), .attaboy_tgt_i(attaboy_tgt_i),
    .w_v_o(w_v_o), .w_clr_o(w_clr_o), .w_jmp_o(w_jmp_o), .w_idx_o(w_idx_o),
    .w_tag_o(w_tag_o), .w_tgt_o(w_tgt_o), .w_yumi_i(w_yumi_i)
  );

  // One cycle: sample outputs at negedge, then step past the next posedge.
  task automatic sample(output logic v, output logic [W-1:0] w,
                        output logic rr, output logic ar, output logic done);
    @(negedge clk_i);
    v = w_v_o; rr = redir_ready_and_o; ar = attaboy_ready_and_o; done = init_done_o;
    w = {w_clr_o, w_jmp_o, w_idx_o, w_tag_o, w_tgt_o};
    @(posedge clk_i); #1;
  endtask

  // Offer one attaboy for a cycle; model it when the DUT takes it.
  task automatic cycle_attaboy(input logic [IW-1:0] idx, output logic rdy);
    attaboy_v_i = 1'b1; attaboy_jmp_i = 1'($urandom); attaboy_idx_i = idx;
    attaboy_tag_i = TW'($urandom); attaboy_tgt_i = GW'({$urandom, $urandom});
    @(negedge clk_i);
    rdy = attaboy_ready_and_o;
    if (rdy) exp_q.push_back({1'b0, attaboy_jmp_i, idx, attaboy_tag_i, attaboy_tgt_i});
    @(posedge clk_i); #1;
    attaboy_v_i = 1'b0;
  endtask

  // Drop queued attaboys the redirect to idx kills.
  task automatic model_kill(input logic [IW-1:0] idx);
    logic [W-1:0] e;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      e = exp_q[i];
      if (e[W-3 -: IW] == idx) exp_q.delete(i);
    end
  endtask

  // Offer one redirect for a cycle; it jumps ahead of buffered attaboys.
  task automatic cycle_redirect(input logic clr, input logic [IW-1:0] idx, output logic rdy);
    redir_v_i = 1'b1; redir_clr_i = clr; redir_jmp_i = 1'($urandom); redir_idx_i = idx;
    redir_tag_i = TW'($urandom); redir_tgt_i = GW'({$urandom, $urandom});
    @(negedge clk_i);
    rdy = redir_ready_and_o;
    if (rdy) begin
      model_kill(idx);
      exp_q.push_front({clr, redir_jmp_i, idx, redir_tag_i, redir_tgt_i});
    end
    @(posedge clk_i); #1;
    redir_v_i = 1'b0;
  endtask

  task automatic test_reset();
    logic v, rr, ar, done;
    logic [W-1:0] w, e;
    reset_n_i = 1'b0;
    #1;
    vectors++;
    if ({init_done_o, w_v_o, redir_ready_and_o, attaboy_ready_and_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b exp 0000",
               {init_done_o, w_v_o, redir_ready_and_o, attaboy_ready_and_o});
    end
    repeat (2) @(posedge clk_i);
    #1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({2'b10, IW'(i), TW'(0), GW'(0)});
    reset_n_i = 1'b1; w_yumi_i = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      sample(v, w, rr, ar, done);
      if (v) begin
        e = exp_q.pop_front();
        vectors++;
        if ({w, done, rr, ar} !== {e, 3'b000}) begin
          miscompares++;
          $display("FAIL sweep: got %h/%b%b%b exp %h/000", w, done, rr, ar, e);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sweep_timeout: got %0d left exp 0", exp_q.size());
    end
    sample(v, w, rr, ar, done);
    vectors++;
    if ({done, v, rr, ar} !== 4'b1011) begin
      miscompares++;
      $display("FAIL init_done_rise: got %b exp 1011", {done, v, rr, ar});
    end
  endtask

  task automatic test_mid_reset();
    logic v, rr, ar, done, seen;
    logic [W-1:0] w, e;
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    exp_q.delete();
    for (int i = 0; i <= 20; i++) exp_q.push_back({2'b10, IW'(i), TW'(0), GW'(0)});
    reset_n_i = 1'b1; w_yumi_i = 1'b1; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      sample(v, w, rr, ar, done);
      if (v && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (w !== e) begin
          miscompares++;
          $display("FAIL partial_sweep: got %h exp %h", w, e);
        end
        if (exp_q.size() == 0) seen = 1'b1;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL partial_sweep_timeout: got %0d left exp 0", exp_q.size());
    end
    reset_n_i = 1'b0;
    #1;
    vectors++;
    if ({init_done_o, w_v_o, w_clr_o, w_idx_o} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b clr=%b idx=%0d exp 0", w_v_o, w_clr_o, w_idx_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({2'b10, IW'(i), TW'(0), GW'(0)});
    reset_n_i = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      sample(v, w, rr, ar, done);
      if (v) begin
        e = exp_q.pop_front();
        vectors++;
        if (w !== e) begin
          miscompares++;
          $display("FAIL restart_sweep: got %h exp %h", w, e);
        end
      end
    end
    sample(v, w, rr, ar, done);
    vectors++;
    if (exp_q.size() != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_done: got left=%0d done=%b exp 0/1", exp_q.size(), done);
    end
  endtask

  // Drain the scoreboard with yumi held high, then expect an idle port.
  task automatic drain_and_check(input string name);
    logic v, rr, ar, done;
    logic [W-1:0] w, e;
    w_yumi_i = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      sample(v, w, rr, ar, done);
      if (v) begin
        e = exp_q.pop_front();
        vectors++;
        if (w !== e) begin
          miscompares++;
          $display("FAIL %s_order: got %h exp %h", name, w, e);
        end
      end
    end
    sample(v, w, rr, ar, done);
    vectors++;
    if (exp_q.size() != 0 || v !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got left=%0d w_v=%b exp 0/0", name, exp_q.size(), v);
    end
    w_yumi_i = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic rdy;
    w_yumi_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle_attaboy(IW'(i), rdy);
      vectors++;
      if (rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_ready: got %b exp 1 at idx %0d", rdy, i);
      end
    end
    cycle_attaboy(IW'(5), rdy);
    vectors++;
    if (rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got %b exp 0", rdy);
    end
    drain_and_check("fifo_full");
  endtask

  task automatic test_redirect_priority();
    logic rdy;
    cycle_attaboy(IW'(5), rdy);
    cycle_attaboy(IW'(7), rdy);
    cycle_redirect(1'b1, IW'(9), rdy);
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_ready: got %b exp 1", rdy);
    end
    drain_and_check("priority");
  endtask

  task automatic test_kill();
    logic rdy;
    logic v, rr, ar, done;
    logic [W-1:0] w;
    cycle_attaboy(IW'(3), rdy);
    cycle_attaboy(IW'(8), rdy);
    cycle_attaboy(IW'(3), rdy);
    cycle_redirect(1'b0, IW'(3), rdy);
    vectors++;
    if (exp_q.size() != 2) begin
      miscompares++;
      $display("FAIL kill_model: got %0d exp 2 entries", exp_q.size());
    end
    drain_and_check("kill");
    sample(v, w, rr, ar, done);
    for (int i = 10; i < 14; i++) begin
      cycle_attaboy(IW'(i), rdy);
      vectors++;
      if (rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL kill_capacity: got %b exp 1 at idx %0d", rdy, i);
      end
    end
    drain_and_check("kill_refill");
  endtask

  task automatic test_same_idx();
    logic rr, ar;
    w_yumi_i = 1'b0;
    redir_v_i = 1'b1; redir_clr_i = 1'b0; redir_jmp_i = 1'b1; redir_idx_i = IW'(30);
    redir_tag_i = TW'($urandom); redir_tgt_i = GW'({$urandom, $urandom});
    attaboy_v_i = 1'b1; attaboy_jmp_i = 1'b0; attaboy_idx_i = IW'(30);
    attaboy_tag_i = TW'($urandom); attaboy_tgt_i = GW'({$urandom, $urandom});
    @(negedge clk_i);
    rr = redir_ready_and_o; ar = attaboy_ready_and_o;
    exp_q.push_back({2'b01, IW'(30), redir_tag_i, redir_tgt_i});
    exp_q.push_back({2'b00, IW'(30), attaboy_tag_i, attaboy_tgt_i});
    @(posedge clk_i); #1;
    redir_v_i = 1'b0; attaboy_v_i = 1'b0;
    vectors++;
    if ({rr, ar} !== 2'b11) begin
      miscompares++;
      $display("FAIL same_idx_ready: got %b exp 11", {rr, ar});
    end
    drain_and_check("same_idx");
  endtask

  task automatic test_back_to_back();
    logic rdy, rr, v;
    logic [W-1:0] w, e;
    w_yumi_i = 1'b0;
    cycle_attaboy(IW'(21), rdy);
    cycle_redirect(1'b1, IW'(20), rdy);
    redir_v_i = 1'b1; redir_clr_i = 1'b0; redir_jmp_i = 1'b1; redir_idx_i = IW'(22);
    redir_tag_i = TW'($urandom); redir_tgt_i = GW'({$urandom, $urandom});
    w_yumi_i = 1'b1;
    @(negedge clk_i);
    rr = redir_ready_and_o; v = w_v_o;
    w = {w_clr_o, w_jmp_o, w_idx_o, w_tag_o, w_tgt_o};
    e = exp_q.pop_front();
    exp_q.push_front({2'b01, IW'(22), redir_tag_i, redir_tgt_i});
    @(posedge clk_i); #1;
    redir_v_i = 1'b0;
    vectors++;
    if ({rr, v, w} !== {2'b11, e}) begin
      miscompares++;
      $display("FAIL b2b_accept: got %b%b %h exp 11 %h", rr, v, w, e);
    end
    drain_and_check("b2b");
  endtask

  initial begin
    reset_n_i = 1'b0; w_yumi_i = 1'b0;
    redir_v_i = 1'b0; redir_clr_i = 1'b0; redir_jmp_i = 1'b0;
    redir_idx_i = '0; redir_tag_i = '0; redir_tgt_i = '0;
    attaboy_v_i = 1'b0; attaboy_jmp_i = 1'b0;
    attaboy_idx_i = '0; attaboy_tag_i = '0; attaboy_tgt_i = '0;
    test_reset();
    test_mid_reset();
    test_fifo_full();
    test_redirect_priority();
    test_kill();
    test_same_idx();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_fe_pred_update_sched.md
Name: bp_fe_pred_update_sched

Overview:
Write-port scheduler for the front-end branch predictor tables (BTB/BHT style).
- After reset, sequences an index sweep that clears every entry; asserts init_done_o when the sweep finishes.
- In run mode, arbitrates table updates between two sources. Redirect (mispredict) updates come from the backend command path and always have priority. Attaboy (correct-prediction) updates are buffered in a small FIFO.
- Sits between the FE command decode and the predictor table's single write port (valid/yumi).

Parameters:
idx_width_p, 6, table index width; the table has 2^idx_width_p entries
tag_width_p, 9, tag field width
tgt_width_p, 39, target address width (vaddr)
fifo_els_p, 4, attaboy FIFO depth (power of 2, >=2)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous assert, active-low
init_done_o  out  1  clear sweep complete
redir_v_i  in  1  redirect update valid
redir_ready_and_o  out  1  redirect accepted when high with redir_v_i
redir_clr_i  in  1  update clears the entry
redir_jmp_i  in  1  entry is an unconditional jump
redir_idx_i  in  idx_width_p  index
redir_tag_i  in  tag_width_p  tag
redir_tgt_i  in  tgt_width_p  target
attaboy_v_i  in  1  attaboy update valid
attaboy_ready_and_o  out  1  attaboy accepted
attaboy_jmp_i  in  1  jump flag
attaboy_idx_i  in  idx_width_p  index
attaboy_tag_i  in  tag_width_p  tag
attaboy_tgt_i  in  tgt_width_p  target
w_v_o  out  1  table write valid
w_clr_o  out  1  write is a clear
w_jmp_o  out  1  jump flag
w_idx_o  out  idx_width_p  write index
w_tag_o  out  tag_width_p  write tag
w_tgt_o  out  tgt_width_p  write target
w_yumi_i  in  1  table consumed the write this cycle

Behaviour:
Reset:
- reset_n_i low asynchronously forces state e_reset, sweep counter 0, redirect holding register empty, FIFO empty (all entry valid bits 0).
- During reset, all outputs are 0.

FSM:
- e_reset -> e_init on the first clock with reset_n_i high.
- e_init:
  - w_v_o=1, w_clr_o=1, w_idx_o=counter; tag, tgt and jmp are 0.
  - Counter increments on w_yumi_i.
  - On w_yumi_i with counter = 2^idx_width_p-1, go to e_run. The counter wraps to 0.
  - Both ready outputs are 0 throughout e_init.
- e_run:
  - init_done_o=1 (registered; rises the cycle after the last init yumi).
  - Stays in e_run until reset.
- A reset mid-sweep restarts the sweep from index 0.

Redirect path (e_run):
- One-entry holding register.
- redir_ready_and_o = ~held | w_yumi_i_on_held. A full register accepts a new redirect in the same cycle it drains.
- Accepted fields are captured on the clock edge.

Attaboy path (e_run):
- FIFO of fifo_els_p entries; each entry carries its own valid bit.
- attaboy_ready_and_o = ~full (count < fifo_els_p). An enqueue and a dequeue in the same cycle with a full FIFO is not accepted.

Write selection (e_run):
- If the redirect register is held, present it.
- Otherwise, if the FIFO head is valid, present it (w_clr_o=0).
- Otherwise w_v_o=0.
- Selection is re-evaluated every cycle. Outputs may change while w_yumi_i=0; the table samples only on yumi.
- w_yumi_i pops the source that was presented.

Kill rule:
- When a redirect is accepted, every FIFO entry whose idx equals redir_idx_i has its valid bit cleared.
- A killed head is popped silently (no write, no yumi needed), one entry per cycle.
- Killed entries still occupy FIFO capacity until popped.

Other rules:
- Simultaneous redirect accept and attaboy accept to the same idx: the attaboy is enqueued valid. It is younger than the redirect, so it is not killed.
- Zero-latency path: an input arriving in an empty state is written no earlier than the next cycle. All outputs are driven from registers plus the select mux.

Decomposition:
- Shared bp_fe_pkg additions:
  - bp_fe_pred_update_sched_state_e {e_reset, e_init, e_run}
  - a `declare_bp_fe_pred_update_s(idx, tag, tgt)` macro with fields clr, jmp, idx, tag, tgt, used for the holding register, the FIFO entries and the write output.
- One natural sub-module: bp_fe_pred_update_fifo. It is a circular FIFO with per-entry valid bits and a parallel idx-match kill input; it owns the head/tail pointers and the count.

Test Plan:
- Reset release with w_yumi_i tied 1, idx_width_p=6:
  - 64 consecutive writes, w_clr_o=1, idx 0..63.
  - init_done_o rises the cycle after idx 63.
  - Both ready outputs stay 0 throughout.
- Drop reset_n_i low at sweep idx 20, then release:
  - Outputs go to 0 immediately (asynchronous).
  - The sweep restarts at idx 0.
- In e_run with w_yumi_i=0, enqueue 4 attaboys (idx 1..4):
  - attaboy_ready_and_o falls after the 4th.
  - A 5th attaboy is not accepted.
  - Then w_yumi_i=1: writes emerge idx 1,2,3,4 in order.
- FIFO holds attaboys idx 5,7; a redirect to idx 9 with clr=1 arrives:
  - The next write is idx 9 with w_clr_o=1.
  - Then idx 5, then idx 7.
- FIFO holds attaboys idx 3,8,3; a redirect to idx 3 is accepted:
  - The write sequence is redirect idx 3, then attaboy idx 8 only.
  - The FIFO is empty afterwards.
- Redirect register held and w_yumi_i=1; a new redirect arrives the same cycle:
  - redir_ready_and_o=1, and the new redirect is written the next cycle.
  - No attaboy is written in between.
